wbs_timer: RTL and testbench
============================

WBS_TIMER -- requirements
Module: wbs_timer

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, clk_i cycles per mtime increment (legal range 1..65535).
REQ-002 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port wbs_cyc_i, input, 1, Wishbone cycle valid.
REQ-005 SHALL have port wbs_stb_i, input, 1, Wishbone strobe.
REQ-006 SHALL have port wbs_we_i, input, 1, 1=write, 0=read.
REQ-007 SHALL have port wbs_sel_i, input, 4, byte enables for writes.
REQ-008 SHALL have port wbs_addr_i, input, 32, byte address; only bits [4:2] decoded.
REQ-009 SHALL have port wbs_dat_i, input, 32, write data.
REQ-010 SHALL have port wbs_dat_o, output, 32, read data, valid only while wbs_ack_o=1.
REQ-011 SHALL have port wbs_ack_o, output, 1, transfer complete.
REQ-012 SHALL have port wbs_err_o, output, 1, transfer error.
REQ-013 SHALL have port xint_mtip_o, output, 1, machine timer interrupt pending.
REQ-014 SHALL have port xint_msip_o, output, 1, machine software interrupt pending.

Function
REQ-015 Register map by wbs_addr_i[4:2] SHALL be: 0 msip (bit0 only, others read 0), 2 mtimecmp[31:0], 3 mtimecmp[63:32], 4 mtime[31:0], 5 mtime[63:32]; indices 1, 6, 7 unmapped.
REQ-016 A request (wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o) SHALL produce exactly one response cycle (ack or err) on the next clock; latency 1.
REQ-017 The response SHALL deassert the cycle after it asserts even if wbs_stb_i stays high; back-to-back throughput is one transfer per 2 cycles.
REQ-018 Writes SHALL update only the bytes with wbs_sel_i set, at the clock edge that asserts the response.
REQ-019 Reads SHALL return the full 32-bit word irrespective of wbs_sel_i.
REQ-020 A tick SHALL occur when the prescale counter equals PRESCALE-1; the counter then wraps to 0; with PRESCALE=1 a tick occurs every cycle.
REQ-021 mtime SHALL increment by 1 on each tick and wrap from 2^64-1 to 0.
REQ-022 A write to either mtime half on a tick cycle SHALL win; the written half takes the bus value and the other half keeps its old value without carry.
REQ-023 xint_mtip_o SHALL be registered as (mtime >= mtimecmp), unsigned 64-bit, using register values from the previous cycle.
REQ-024 xint_msip_o SHALL equal msip bit0 directly from its register.
REQ-025 wbs_ack_o and wbs_err_o SHALL never be asserted in the same cycle.
REQ-026 A request with wbs_cyc_i=0 or wbs_stb_i=0 SHALL be ignored and SHALL not modify any state.

Reset
REQ-027 Reset SHALL force wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0, mtime=0, prescale counter=0, msip=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, and xint_mtip_o=0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no response; the first request after reset release SHALL be serviced normally.

Configuration
REQ-029 With WBS_TIMER_ERR_EN defined, accesses to unmapped indices SHALL respond with wbs_err_o and leave all state unchanged.
REQ-030 Without WBS_TIMER_ERR_EN, unmapped reads SHALL ack with data 0, unmapped writes SHALL ack and be discarded, and wbs_err_o SHALL be tied to 0.

Structure
REQ-031 Register index constants, the mtimecmp reset value and the msip bit position SHALL live in shared package titan_pkg.
REQ-032 Tick generation SHALL be a sub-module wbs_timer_prescaler (inputs clk_i and rst_i, parameter PRESCALE, output tick).

Verification
REQ-033 Reset, then idle 10 cycles with PRESCALE=1 -> read index 4 returns 10 ±1 per bench alignment, xint_mtip_o=0.
REQ-034 Write mtimecmp={0,20} at t0 with mtime≈5 -> xint_mtip_o rises one cycle after mtime reaches 20 and stays high until mtimecmp is rewritten higher.
REQ-035 Write 0x1 to index 0 with sel=4'b0001 -> xint_msip_o=1 the cycle after ack; write with sel=4'b0000 leaves it unchanged.
REQ-036 Hold stb high for 6 cycles on a read -> ack pulses on cycles 2, 4 and 6 only, never two consecutive cycles.
REQ-037 Access index 6 -> with WBS_TIMER_ERR_EN, err=1 and ack=0; without it, ack=1 and data 0.
REQ-038 Write 0xFFFF_FFFF to mtime lo and hi, PRESCALE=4 -> mtime wraps to 0 after 4 cycles; assert rst_i low during an in-flight write -> no ack and register unchanged.

Source files
------------

// File: rtl/titan_pkg.sv
// Shared constants for the Wishbone machine timer.
// Holds the register index map (decoded from wbs_addr_i[4:2]), the mtimecmp
// reset value and the position of the software interrupt bit in msip.
// No ports; imported with "import titan_pkg::*;".
package titan_pkg;

  localparam logic [2:0]  IDX_MSIP        = 3'd0;
  localparam logic [2:0]  IDX_MTIMECMP_LO = 3'd2;
  localparam logic [2:0]  IDX_MTIMECMP_HI = 3'd3;
  localparam logic [2:0]  IDX_MTIME_LO    = 3'd4;
  localparam logic [2:0]  IDX_MTIME_HI    = 3'd5;

  // All-ones keeps the timer interrupt quiet until software programs a compare.
  localparam logic [63:0] MTIMECMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam int          MSIP_BIT        = 0;

endpackage

// File: rtl/wbs_timer_prescaler.sv
// Tick generator for the machine timer.
// Counts clk_i cycles and raises tick for one cycle every PRESCALE cycles
// (every cycle when PRESCALE = 1).
// Ports:
//   clk_i - clock, rising edge
//   rst_i - asynchronous active-low reset, clears the counter
//   tick  - high while the counter sits at its terminal value PRESCALE-1
module wbs_timer_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick
);

  localparam logic [15:0] TERM = 16'(PRESCALE - 1);

  logic [15:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/wbs_timer.sv
// Wishbone slave machine timer (mtime / mtimecmp / msip).
// Single-cycle-latency register slave: every accepted request is answered
// with exactly one ack (or err) pulse on the following clock.
// Optional feature: define WBS_TIMER_ERR_EN to answer unmapped indices with
// wbs_err_o instead of a data-0 / discarded-write ack.
// Ports:
//   clk_i, rst_i      - clock (rising edge), async active-low reset
//   wbs_cyc_i/stb_i   - Wishbone cycle / strobe
//   wbs_we_i          - 1 = write, 0 = read
//   wbs_sel_i         - byte enables for writes
//   wbs_addr_i        - byte address, bits [4:2] select the register
//   wbs_dat_i/dat_o   - write data / read data (valid with ack)
//   wbs_ack_o/err_o   - transfer complete / transfer error
//   xint_mtip_o       - machine timer interrupt pending (mtime >= mtimecmp)
//   xint_msip_o       - machine software interrupt pending (msip bit 0)
module wbs_timer
  import titan_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip;
  logic        tick;
  logic        req;
  logic        mapped;
  logic        wr;
  logic [2:0]  idx;
  logic [31:0] rd_data;
  logic        unused_addr;

  assign unused_addr = ^{wbs_addr_i[31:5], wbs_addr_i[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = sel[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    return res;
  endfunction

  wbs_timer_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .tick (tick)
  );

  // A response in flight blocks a new request, which caps a held strobe at
  // one transfer every two cycles.
  assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
  assign idx = wbs_addr_i[4:2];
  assign wr  = req & wbs_we_i & mapped;

  always_comb begin
    mapped  = 1'b0;
    rd_data = '0;
    case (idx)
      IDX_MSIP: begin
        mapped            = 1'b1;
        rd_data[MSIP_BIT] = msip;
      end
      IDX_MTIMECMP_LO: begin mapped = 1'b1; rd_data = mtimecmp[31:0];  end
      IDX_MTIMECMP_HI: begin mapped = 1'b1; rd_data = mtimecmp[63:32]; end
      IDX_MTIME_LO:    begin mapped = 1'b1; rd_data = mtime[31:0];     end
      IDX_MTIME_HI:    begin mapped = 1'b1; rd_data = mtime[63:32];    end
      default: ;
    endcase
  end

  // Bus response stage
`ifdef WBS_TIMER_ERR_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req & mapped;
      wbs_err_o <= req & ~mapped;
      wbs_dat_o <= (req & ~wbs_we_i) ? rd_data : '0;
    end
  end
`else
  assign wbs_err_o = 1'b0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= (req & ~wbs_we_i) ? rd_data : '0;
    end
  end
`endif

  // Register file stage; a bus write to an mtime half overrides the tick
  // and leaves the other half untouched (no carry).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      msip     <= 1'b0;
    end else begin
      if (wr && idx == IDX_MSIP && wbs_sel_i[MSIP_BIT / 8]) begin
        msip <= wbs_dat_i[MSIP_BIT];
      end
      if (wr && idx == IDX_MTIMECMP_LO) begin
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], wbs_dat_i, wbs_sel_i);
      end
      if (wr && idx == IDX_MTIMECMP_HI) begin
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wbs_dat_i, wbs_sel_i);
      end
      if (wr && idx == IDX_MTIME_LO) begin
        mtime[31:0] <= merge_bytes(mtime[31:0], wbs_dat_i, wbs_sel_i);
      end else if (wr && idx == IDX_MTIME_HI) begin
        mtime[63:32] <= merge_bytes(mtime[63:32], wbs_dat_i, wbs_sel_i);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
    end
  end

  // Interrupt stage: compare uses the register values of the previous cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      xint_mtip_o <= 1'b0;
    end else begin
      xint_mtip_o <= (mtime >= mtimecmp);
    end
  end

  assign xint_msip_o = msip;

endmodule

// File: tb/tb_wbs_timer.sv
// Directed bench for wbs_timer: one instance with PRESCALE=1 (dut "a") and one
// with PRESCALE=4 (dut "b"), sharing clock, reset and bus inputs except cyc.
module tb_wbs_timer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc_a, cyc_b, stb, we;
  logic [3:0]  sel;
  logic [31:0] addr, wdat;
  logic [31:0] dat_a, dat_b;
  logic        ack_a, ack_b, err_a, err_b;
  logic        mtip_a, mtip_b, msip_a, msip_b;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  always #5 clk = ~clk;

  // Rising edges counted since reset release; dut b ticks when edge_n % 4 == 0.
  always @(posedge clk) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  wbs_timer #(.PRESCALE(1)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n),
    .wbs_cyc_i(cyc_a), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_addr_i(addr), .wbs_dat_i(wdat), .wbs_dat_o(dat_a),
    .wbs_ack_o(ack_a), .wbs_err_o(err_a),
    .xint_mtip_o(mtip_a), .xint_msip_o(msip_a)
  );

  wbs_timer #(.PRESCALE(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n),
    .wbs_cyc_i(cyc_b), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_addr_i(addr), .wbs_dat_i(wdat), .wbs_dat_o(dat_b),
    .wbs_ack_o(ack_b), .wbs_err_o(err_b),
    .xint_mtip_o(mtip_b), .xint_msip_o(msip_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the edge that
  // follows the response, so the bus is idle and ready for the next request.
  task automatic bus_xfer(input bit d, input bit w, input logic [2:0] idx,
                          input logic [31:0] data, input logic [3:0] be,
                          output logic ack, output logic err, output logic [31:0] rd);
    cyc_a = ~d; cyc_b = d; stb = 1'b1; we = w;
    addr = {27'd0, idx, 2'b00}; wdat = data; sel = be;
    @(posedge clk); #1;
    ack = d ? ack_b : ack_a;
    err = d ? err_b : err_a;
    rd  = d ? dat_b : dat_a;
    cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr_chk(input string tag, input bit d, input logic [2:0] idx,
                        input logic [31:0] data, input logic [3:0] be);
    logic a, e;
    logic [31:0] r;
    bus_xfer(d, 1'b1, idx, data, be, a, e, r);
    chk(tag, {62'd0, a, e}, 64'd2);
  endtask

  task automatic rd_chk(input string tag, input bit d, input logic [2:0] idx,
                        input logic [31:0] exp);
    logic a, e;
    logic [31:0] r;
    bus_xfer(d, 1'b0, idx, 32'd0, 4'hF, a, e, r);
    chk({tag, "_ack"}, {62'd0, a, e}, 64'd2);
    chk(tag, {32'd0, r}, {32'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a, e;
    logic [31:0] r;

    rst_n = 1'b0; cyc_a = 0; cyc_b = 0; stb = 0; we = 0;
    sel = '0; addr = '0; wdat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",  {63'd0, ack_a},  64'd0);
    chk("rst_err",  {63'd0, err_a},  64'd0);
    chk("rst_dat",  {32'd0, dat_a},  64'd0);
    chk("rst_mtip", {62'd0, mtip_a, mtip_b}, 64'd0);
    chk("rst_msip", {63'd0, msip_a}, 64'd0);

    // Idle count with PRESCALE=1
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_mtip", {63'd0, mtip_a}, 64'd0);
    rd_chk("idle_mtime_lo", 1'b0, 3'd4, 32'd10);
    rd_chk("rst_cmp_lo", 1'b0, 3'd2, 32'hFFFF_FFFF);
    rd_chk("rst_cmp_hi", 1'b0, 3'd3, 32'hFFFF_FFFF);

    // Strobe without cyc must be ignored
    cyc_a = 1'b0; stb = 1'b1; we = 1'b1; addr = 32'h0; wdat = 32'h1; sel = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("nocyc_ack",  {63'd0, ack_a},  64'd0);
    chk("nocyc_msip", {63'd0, msip_a}, 64'd0);
    stb = 1'b0; we = 1'b0;

    // Software interrupt bit
    wr_chk("msip_set", 1'b0, 3'd0, 32'h1, 4'b0001);
    chk("msip_set_o", {63'd0, msip_a}, 64'd1);
    wr_chk("msip_sel0", 1'b0, 3'd0, 32'h0, 4'b0000);
    chk("msip_sel0_o", {63'd0, msip_a}, 64'd1);
    wr_chk("msip_ones", 1'b0, 3'd0, 32'hFFFF_FFFF, 4'hF);
    rd_chk("msip_rd", 1'b0, 3'd0, 32'h1);
    wr_chk("msip_clr", 1'b0, 3'd0, 32'h0, 4'b0001);
    chk("msip_clr_o", {63'd0, msip_a}, 64'd0);

    // Timer compare: mtime=5, cmp={0,20}; mtime is 10 when these writes finish
    wr_chk("mtime_lo5", 1'b0, 3'd4, 32'd5, 4'hF);
    wr_chk("cmp_hi0",   1'b0, 3'd3, 32'd0, 4'hF);
    wr_chk("cmp_lo20",  1'b0, 3'd2, 32'd20, 4'hF);
    repeat (10) @(posedge clk);
    #1;
    chk("mtip_before", {63'd0, mtip_a}, 64'd0);
    @(posedge clk); #1;
    chk("mtip_rise", {63'd0, mtip_a}, 64'd1);
    rd_chk("mtime_at21", 1'b0, 3'd4, 32'd21);
    repeat (5) @(posedge clk);
    #1;
    chk("mtip_hold", {63'd0, mtip_a}, 64'd1);
    wr_chk("cmp_lo1000", 1'b0, 3'd2, 32'd1000, 4'hF);
    chk("mtip_fall", {63'd0, mtip_a}, 64'd0);

    // Held strobe on a read: ack on alternate cycles only
    cyc_a = 1'b1; stb = 1'b1; we = 1'b0; addr = {27'd0, 3'd2, 2'b00}; sel = 4'h0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stream_ack%0d", i), {63'd0, ack_a}, {63'd0, i[0]});
      if (i[0]) chk($sformatf("stream_dat%0d", i), {32'd0, dat_a}, 64'd1000);
    end
    cyc_a = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    // Byte lanes on write, sel ignored on read
    wr_chk("cmp_lanes", 1'b0, 3'd2, 32'hAABB_CCDD, 4'b0101);
    bus_xfer(1'b0, 1'b0, 3'd2, 32'd0, 4'b0000, a, e, r);
    chk("lanes_rd", {32'd0, r}, 64'h0000_0000_00BB_03DD);

    // Unmapped indices
    bus_xfer(1'b0, 1'b0, 3'd6, 32'd0, 4'hF, a, e, r);
`ifdef WBS_TIMER_ERR_EN
    chk("unmap_rd_resp", {62'd0, a, e}, 64'd1);
`else
    chk("unmap_rd_resp", {62'd0, a, e}, 64'd2);
    chk("unmap_rd_dat",  {32'd0, r},    64'd0);
`endif
    bus_xfer(1'b0, 1'b1, 3'd1, 32'h5A5A_5A5A, 4'hF, a, e, r);
`ifdef WBS_TIMER_ERR_EN
    chk("unmap_wr_resp", {62'd0, a, e}, 64'd1);
`else
    chk("unmap_wr_resp", {62'd0, a, e}, 64'd2);
`endif
    rd_chk("unmap_keep", 1'b0, 3'd2, 32'h00BB_03DD);
    chk("unmap_msip", {63'd0, msip_a}, 64'd0);

    // 64-bit wrap with PRESCALE=4; lo is written on a tick edge and must win
    while (edge_n % 4 != 1) begin
      @(posedge clk); #1;
    end
    wr_chk("wrap_hi", 1'b1, 3'd5, 32'hFFFF_FFFF, 4'hF);
    wr_chk("wrap_lo", 1'b1, 3'd4, 32'hFFFF_FFFF, 4'hF);
    rd_chk("wrap_lo_full", 1'b1, 3'd4, 32'hFFFF_FFFF);
    rd_chk("wrap_hi_full", 1'b1, 3'd5, 32'hFFFF_FFFF);
    rd_chk("wrap_lo_zero", 1'b1, 3'd4, 32'd0);
    rd_chk("wrap_hi_zero", 1'b1, 3'd5, 32'd0);
    rd_chk("wrap_lo_one",  1'b1, 3'd4, 32'd1);

    // Reset during an in-flight write: no response, write lost
    cyc_a = 1'b1; stb = 1'b1; we = 1'b1; addr = {27'd0, 3'd2, 2'b00};
    wdat = 32'h1234_5678; sel = 4'hF;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ack", {63'd0, ack_a}, 64'd0);
    cyc_a = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_chk("rst_mid_cmp", 1'b0, 3'd2, 32'hFFFF_FFFF);
    chk("rst_mid_mtip", {63'd0, mtip_a}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
